// File: rtl/dram_read_master_pkg.sv
// Shared definitions for the DRAM read master: FSM states and beat geometry.
package dram_read_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = 5;

endpackage

// File: rtl/dram_rd_fifo.sv
// dram_rd_fifo: synchronous DATA_W x DEPTH beat FIFO with first-word-fall-through head.
// Latency: a push is visible on head/valid the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
module dram_rd_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign valid   = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_read_master.sv
// dram_read_master: AXI AR/R initiator fetching a run of beats into a FWFT stream (RID_CHECK_EN: sticky RID check).
// Latency: first AR two cycles after start; data_valid_out the cycle after the R beat that filled an empty FIFO.
// Backpressure: an AR issues only once FIFO space is reserved for its beats, so rready holds high all run.
module dram_read_master
  import dram_read_master_pkg::*;
#(
  parameter int ADDR_W    = 33,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 8,
  parameter int ARID      = 0,
  parameter int MAX_BURST = 8,
  parameter int MAX_OUTST = 2,
  parameter int FIFO_D    = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [CNT_W-1:0]  num_beats_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              rid_err_out,
  input  logic              axi0_arready_in,
  output logic [ID_W-1:0]   axi0_arid_out,
  output logic [ADDR_W-1:0] axi0_araddr_out,
  output logic [7:0]        axi0_arlen_out,
  output logic              axi0_arvalid_out,
  input  logic [ID_W-1:0]   axi0_rid_in,
  input  logic              axi0_rvalid_in,
  input  logic [DATA_W-1:0] axi0_rdata_in,
  output logic              axi0_rready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  input  logic              data_ready_in
);

  localparam int CW = $clog2(FIFO_D) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining, total, rcv_cnt;
  logic [CW-1:0]     reserved, fifo_cnt, len, free_cnt;
  logic [OW-1:0]     outst;
  logic [BW-1:0]     burst_beat;
  logic [8:0]        ar_beats;
  logic              accept, ar_hs, r_hs, issue, final_beat, burst_end;
  logic              unused_low_addr;

  assign accept          = (state == ST_IDLE) && !busy_out && start_in;
  assign ar_hs           = axi0_arvalid_out && axi0_arready_in;
  assign r_hs            = axi0_rvalid_in && axi0_rready_out;
  assign axi0_rready_out = (state == ST_REQ) || (state == ST_WAIT);
  assign axi0_arid_out   = ID_W'(ARID);
  assign unused_low_addr = ^base_addr_in[BEAT_SHIFT-1:0];

  assign len        = (remaining < CNT_W'(MAX_BURST)) ? CW'(remaining) : CW'(MAX_BURST);
  // Reserved beats count as occupied so every beat in flight already has a slot.
  assign free_cnt   = CW'(FIFO_D) - fifo_cnt - reserved;
  assign issue      = (state == ST_REQ) && !axi0_arvalid_out && (remaining != '0) &&
                      (outst < OW'(MAX_OUTST)) && (free_cnt >= len);
  assign ar_beats   = {1'b0, axi0_arlen_out} + 9'd1;
  assign final_beat = (rcv_cnt + CNT_W'(1)) == total;
  assign burst_end  = (burst_beat == BW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = (num_beats_in == '0) ? ST_DONE : ST_REQ;
      ST_REQ:  if (remaining == '0) state_nx = ST_WAIT;
      ST_WAIT: if (rcv_cnt == total) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q           <= '0;
      remaining        <= '0;
      total            <= '0;
      rcv_cnt          <= '0;
      reserved         <= '0;
      outst            <= '0;
      burst_beat       <= '0;
      axi0_arvalid_out <= 1'b0;
      axi0_araddr_out  <= '0;
      axi0_arlen_out   <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      // done follows the DONE state by one cycle; busy covers that cycle too.
      done_out <= (state == ST_DONE);
      if (accept)        busy_out <= 1'b1;
      else if (done_out) busy_out <= 1'b0;

      if (accept) begin
        addr_q    <= {base_addr_in[ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
        remaining <= num_beats_in;
        total     <= num_beats_in;
      end else if (ar_hs) begin
        addr_q    <= addr_q + (ADDR_W'(ar_beats) << BEAT_SHIFT);
        remaining <= remaining - CNT_W'(ar_beats);
      end

      if (issue) begin
        axi0_arvalid_out <= 1'b1;
        axi0_araddr_out  <= addr_q;
        axi0_arlen_out   <= 8'(len - CW'(1));
      end else if (ar_hs) begin
        axi0_arvalid_out <= 1'b0;
      end

      reserved <= reserved + (ar_hs ? CW'(ar_beats) : CW'(0)) - CW'(r_hs);
      outst    <= outst + OW'(ar_hs) - OW'(r_hs && (burst_end || final_beat));

      if (accept) begin
        rcv_cnt    <= '0;
        burst_beat <= '0;
      end else if (r_hs) begin
        rcv_cnt    <= rcv_cnt + CNT_W'(1);
        burst_beat <= burst_beat + BW'(1);
      end
    end
  end

`ifdef RID_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                      rid_err_out <= 1'b0;
    else if (accept)                              rid_err_out <= 1'b0;
    else if (r_hs && axi0_rid_in != ID_W'(ARID))  rid_err_out <= 1'b1;
  end
`else
  logic unused_rid;
  assign rid_err_out = 1'b0;
  assign unused_rid  = ^axi0_rid_in;
`endif

  dram_rd_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_D),
    .CNT_W (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (r_hs),
    .push_data(axi0_rdata_in),
    .pop      (data_ready_in),
    .head     (data_out),
    .valid    (data_valid_out),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_dram_read_master.sv
// Directed bench for dram_read_master: vector table of commands plus stall, AR hold, null, reset and RID sequences.
module tb_dram_read_master;

`ifdef RID_CHECK_EN
  localparam logic EXP_RID_ERR = 1'b1;
`else
  localparam logic EXP_RID_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [32:0]  base_addr_in;
  logic [15:0]  num_beats_in;
  logic         busy_out, done_out, rid_err_out;
  logic         axi0_arready_in;
  logic [7:0]   axi0_arid_out;
  logic [32:0]  axi0_araddr_out;
  logic [7:0]   axi0_arlen_out;
  logic         axi0_arvalid_out;
  logic [7:0]   axi0_rid_in;
  logic         axi0_rvalid_in;
  logic [255:0] axi0_rdata_in;
  logic         axi0_rready_out;
  logic [255:0] data_out;
  logic         data_valid_out;
  logic         data_ready_in;

  dram_read_master dut (
    .clk(clk), .rst(rst), .start_in(start_in), .base_addr_in(base_addr_in),
    .num_beats_in(num_beats_in), .busy_out(busy_out), .done_out(done_out),
    .rid_err_out(rid_err_out), .axi0_arready_in(axi0_arready_in),
    .axi0_arid_out(axi0_arid_out), .axi0_araddr_out(axi0_araddr_out),
    .axi0_arlen_out(axi0_arlen_out), .axi0_arvalid_out(axi0_arvalid_out),
    .axi0_rid_in(axi0_rid_in), .axi0_rvalid_in(axi0_rvalid_in),
    .axi0_rdata_in(axi0_rdata_in), .axi0_rready_out(axi0_rready_out),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [32:0] addr;
    logic [7:0]  len;
  } ar_t;

  int           errors = 0;
  int           checks = 0;
  int           done_cnt = 0;
  int           done_base = 0;
  int           n_out = 0;
  logic [255:0] exp_q[$];
  ar_t          ar_log[$];
  logic [32:0]  beat_q[$];
  logic [7:0]   rid_val = 8'h00;

  // Beat payload is derived from its byte address so order and address are both visible.
  function automatic logic [255:0] pat(input logic [32:0] a);
    logic [255:0] v;
    v          = '0;
    v[32:0]    = a;
    v[159:128] = 32'hC0DE_F00D;
    v[255:224] = ~a[31:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ar(input string name, input int idx, input logic [32:0] addr, input logic [7:0] len);
    if (idx >= ar_log.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: AR #%0d missing, only %0d issued", name, idx, ar_log.size());
    end else begin
      chk({name, "_addr"}, 256'(ar_log[idx].addr), 256'(addr));
      chk({name, "_len"},  256'(ar_log[idx].len),  256'(len));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [32:0] base, input logic [15:0] n);
    logic [32:0] a;
    a = {base[32:5], 5'b0};
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(pat(a));
      a = a + 33'd32;
    end
    done_base    = done_cnt;
    start_in     = 1'b1;
    base_addr_in = base;
    num_beats_in = n;
    tick();
    start_in     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (done_cnt == done_base && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_done_seen"}, 256'(done_cnt != done_base), 256'(1));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_beats_left"}, 256'(exp_q.size()), 256'(0));
  endtask

  // AXI read responder: logs every AR and returns its beats back-to-back in order.
  logic        r_ar_take, r_take, r_in_rst;
  logic [32:0] r_addr;
  logic [7:0]  r_len;
  initial begin
    axi0_rvalid_in = 1'b0;
    axi0_rdata_in  = '0;
    axi0_rid_in    = '0;
    forever begin
      @(negedge clk);
      r_in_rst  = rst;
      r_ar_take = axi0_arvalid_out && axi0_arready_in;
      r_take    = axi0_rvalid_in && axi0_rready_out;
      r_addr    = axi0_araddr_out;
      r_len     = axi0_arlen_out;
      @(posedge clk);
      #1;
      if (r_in_rst) begin
        beat_q.delete();
      end else begin
        if (r_take) void'(beat_q.pop_front());
        if (r_ar_take) begin
          ar_log.push_back({r_addr, r_len});
          for (int i = 0; i <= int'(r_len); i++) beat_q.push_back(r_addr + 33'(i * 32));
        end
      end
      axi0_rvalid_in = (beat_q.size() != 0);
      axi0_rdata_in  = axi0_rvalid_in ? pat(beat_q[0]) : '0;
      axi0_rid_in    = rid_val;
    end
  end

  // Stream monitor and done counter.
  initial forever begin
    @(negedge clk);
    if (done_out) done_cnt++;
    if (data_valid_out && data_ready_in && !rst) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: beat 0x%0h arrived with nothing expected", data_out);
      end else begin
        chk("stream_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [32:0] base;
    logic [15:0] beats;
    int          n_ar;
    logic [32:0] a0;
    logic [7:0]  l0;
    logic [32:0] al;
    logic [7:0]  ll;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{33'h0,          16'd8,  1, 33'h0,          8'd7, 33'h0,     8'd7};
    vt[1] = '{33'h45,         16'd3,  1, 33'h40,         8'd2, 33'h40,    8'd2};
    vt[2] = '{33'h1E0,        16'd17, 3, 33'h1E0,        8'd7, 33'h3E0,   8'd0};
    vt[3] = '{33'h1_FFFF_FFE0, 16'd9, 2, 33'h1_FFFF_FFE0, 8'd7, 33'h0E0,  8'd0};
    vt[4] = '{33'h1000,       16'd16, 2, 33'h1000,       8'd7, 33'h1100,  8'd7};

    rst = 1'b1; start_in = 1'b0; base_addr_in = '0; num_beats_in = '0;
    axi0_arready_in = 1'b1; data_ready_in = 1'b1;
    tick();
    tick();
    chk("rst_arvalid", 256'(axi0_arvalid_out), 256'(0));
    chk("rst_araddr",  256'(axi0_araddr_out),  256'(0));
    chk("rst_arlen",   256'(axi0_arlen_out),   256'(0));
    chk("rst_arid",    256'(axi0_arid_out),    256'(0));
    chk("rst_rready",  256'(axi0_rready_out),  256'(0));
    chk("rst_busy",    256'(busy_out),         256'(0));
    chk("rst_done",    256'(done_out),         256'(0));
    chk("rst_riderr",  256'(rid_err_out),      256'(0));
    chk("rst_dvalid",  256'(data_valid_out),   256'(0));
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ar_log.delete();
      n_out = 0;
      start_cmd(vt[v].base, vt[v].beats);
      chk("vec_busy_on", 256'(busy_out), 256'(1));
      wait_done("vec", 300);
      chk("vec_busy_off", 256'(busy_out), 256'(0));
      wait_drain("vec", 100);
      tick();
      chk("vec_ar_count", 256'(ar_log.size()), 256'(vt[v].n_ar));
      chk_ar("vec_ar_first", 0, vt[v].a0, vt[v].l0);
      chk_ar("vec_ar_last", vt[v].n_ar - 1, vt[v].al, vt[v].ll);
      chk("vec_beats_out", 256'(n_out), 256'(vt[v].beats));
      chk("vec_done_pulses", 256'(done_cnt - done_base), 256'(1));
    end

    // Stream stalled: only two full bursts fit, third waits for FIFO space.
    ar_log.delete();
    n_out = 0;
    data_ready_in = 1'b0;
    start_cmd(33'h0, 16'd20);
    for (int i = 0; i < 40; i++) tick();
    chk("stall_ar_count", 256'(ar_log.size()), 256'(2));
    chk_ar("stall_ar0", 0, 33'h000, 8'd7);
    chk_ar("stall_ar1", 1, 33'h100, 8'd7);
    chk("stall_busy",   256'(busy_out),       256'(1));
    chk("stall_dvalid", 256'(data_valid_out), 256'(1));
    data_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    data_ready_in = 1'b0;
    chk("stall_popped", 256'(n_out), 256'(4));
    for (int i = 0; i < 20; i++) tick();
    chk("stall_ar_count2", 256'(ar_log.size()), 256'(3));
    chk_ar("stall_ar2", 2, 33'h200, 8'd3);
    data_ready_in = 1'b1;
    wait_done("stall", 200);
    wait_drain("stall", 100);
    tick();
    chk("stall_beats_out", 256'(n_out), 256'(20));
    chk("stall_done_pulses", 256'(done_cnt - done_base), 256'(1));

    // AR held while arready is low.
    ar_log.delete();
    n_out = 0;
    axi0_arready_in = 1'b0;
    start_cmd(33'h300, 16'd5);
    for (int i = 0; i < 10 && !axi0_arvalid_out; i++) tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_arvalid", 256'(axi0_arvalid_out), 256'(1));
      chk("hold_araddr",  256'(axi0_araddr_out),  256'(33'h300));
      chk("hold_arlen",   256'(axi0_arlen_out),   256'(4));
      tick();
    end
    chk("hold_arvalid_last", 256'(axi0_arvalid_out), 256'(1));
    axi0_arready_in = 1'b1;
    tick();
    chk("hold_arvalid_drop", 256'(axi0_arvalid_out), 256'(0));
    wait_done("hold", 200);
    wait_drain("hold", 100);
    tick();
    chk("hold_ar_count", 256'(ar_log.size()), 256'(1));
    chk("hold_beats_out", 256'(n_out), 256'(5));

    // Null command.
    ar_log.delete();
    start_cmd(33'h80, 16'd0);
    chk("null_busy_c1", 256'(busy_out), 256'(1));
    chk("null_done_c1", 256'(done_out), 256'(0));
    tick();
    chk("null_busy_c2", 256'(busy_out), 256'(1));
    chk("null_done_c2", 256'(done_out), 256'(1));
    tick();
    chk("null_busy_c3", 256'(busy_out), 256'(0));
    chk("null_done_c3", 256'(done_out), 256'(0));
    for (int i = 0; i < 4; i++) tick();
    chk("null_ar_count", 256'(ar_log.size()), 256'(0));

    // Reset in the middle of a burst, then a fresh one-beat command with a foreign RID.
    ar_log.delete();
    data_ready_in = 1'b0;
    start_cmd(33'h400, 16'd16);
    for (int i = 0; i < 8; i++) tick();
    chk("mid_dvalid", 256'(data_valid_out), 256'(1));
    rst = 1'b1;
    tick();
    chk("mrst_arvalid", 256'(axi0_arvalid_out), 256'(0));
    chk("mrst_araddr",  256'(axi0_araddr_out),  256'(0));
    chk("mrst_arlen",   256'(axi0_arlen_out),   256'(0));
    chk("mrst_rready",  256'(axi0_rready_out),  256'(0));
    chk("mrst_busy",    256'(busy_out),         256'(0));
    chk("mrst_done",    256'(done_out),         256'(0));
    chk("mrst_riderr",  256'(rid_err_out),      256'(0));
    chk("mrst_dvalid",  256'(data_valid_out),   256'(0));
    rst = 1'b0;
    exp_q.delete();
    ar_log.delete();
    tick();
    tick();
    rid_val = 8'h05;
    data_ready_in = 1'b1;
    n_out = 0;
    start_cmd(33'h20, 16'd1);
    wait_done("post_rst", 100);
    wait_drain("post_rst", 50);
    tick();
    chk("post_rst_ar_count", 256'(ar_log.size()), 256'(1));
    chk_ar("post_rst_ar", 0, 33'h20, 8'd0);
    chk("post_rst_beats", 256'(n_out), 256'(1));
    chk("rid_err_set", 256'(rid_err_out), 256'(EXP_RID_ERR));
    for (int i = 0; i < 3; i++) tick();
    chk("rid_err_sticky", 256'(rid_err_out), 256'(EXP_RID_ERR));
    rid_val = 8'h00;
    start_cmd(33'h40, 16'd1);
    chk("rid_err_clear", 256'(rid_err_out), 256'(0));
    wait_done("rid_clean", 100);
    wait_drain("rid_clean", 50);
    chk("rid_err_clean_run", 256'(rid_err_out), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
